// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder/subtractor.
package pipe_adder_pkg;

    localparam int unsigned PA_DEFAULT_WIDTH  = 32;
    localparam int unsigned PA_DEFAULT_STAGES = 4;

    function automatic logic pa_params_ok(input int unsigned width, input int unsigned stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple of 1-bit full-adder cells; exposes the carry into the MSB for overflow.
module adder_chunk
    import pipe_adder_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o,
    output logic         cmsb_o
);

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic ci;
        logic co;

        if (i == 0) begin : g_lsb
            assign ci = c_i;
        end else begin : g_up
            assign ci = g_fa[i-1].co;
        end

        assign s_o[i] = a_i[i] ^ b_i[i] ^ ci;
        assign co     = (a_i[i] & b_i[i]) | (ci & (a_i[i] ^ b_i[i]));
    end

    assign c_o    = g_fa[N-1].co;
    assign cmsb_o = g_fa[N-1].ci;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit ripple slice per stage,
// with operands skewed forward and partial results accumulated so all bits emerge together.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = PA_DEFAULT_WIDTH,
    parameter int unsigned STAGES = PA_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if (!pa_params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipe_adder: WIDTH must be >= 2, STAGES >= 1 and WIDTH divisible by STAGES");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // AW: operand bits still unconsumed on entry; RW: result bits completed on exit.
        localparam int unsigned AW = WIDTH - k * CHUNK;
        localparam int unsigned RW = (k + 1) * CHUNK;

        logic [AW-1:0]    a_in;
        logic [AW-1:0]    b_in;
        logic             v_in;
        logic             sub_in;
        logic             c_in;
        logic [CHUNK-1:0] s_chunk;
        logic             c_out;
        logic             c_msb;
        logic             v_q;
        logic             c_q;
        logic             c_d;
        logic [RW-1:0]    res_q;
        logic [RW-1:0]    res_d;

        if (k == 0) begin : g_head
            assign a_in   = a;
            assign b_in   = b;
            assign v_in   = in_valid;
            assign sub_in = sub;
            assign c_in   = cin ^ sub;
            assign res_d  = s_chunk;
        end else begin : g_tail
            assign a_in   = g_stg[k-1].g_ops.a_q;
            assign b_in   = g_stg[k-1].g_ops.b_q;
            assign v_in   = g_stg[k-1].v_q;
            assign sub_in = g_stg[k-1].g_ops.sub_q;
            assign c_in   = g_stg[k-1].c_q;
            assign res_d  = {s_chunk, g_stg[k-1].res_q};
        end

        adder_chunk #(.N(CHUNK)) u_chunk (
            .a_i    (a_in[CHUNK-1:0]),
            .b_i    (b_in[CHUNK-1:0] ^ {CHUNK{sub_in}}),
            .c_i    (c_in),
            .s_o    (s_chunk),
            .c_o    (c_out),
            .cmsb_o (c_msb)
        );

        assign c_d = c_out;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= c_d;
                    res_q <= res_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            localparam int unsigned OW = AW - CHUNK;

            logic [OW-1:0] a_q;
            logic [OW-1:0] b_q;
            logic          sub_q;
            logic          unused_c_msb;

            assign unused_c_msb = c_msb;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (en && v_in) begin
                    a_q   <= a_in[AW-1:CHUNK];
                    b_q   <= b_in[AW-1:CHUNK];
                    sub_q <= sub_in;
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en && v_in) begin
                    ovf_q <= c_msb ^ c_out;
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign sum       = g_stg[STAGES-1].res_q;
    assign cout      = g_stg[STAGES-1].c_q;
    assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined two's-complement adder/subtractor built from ripple chunks of 1-bit full-adder cells.
- WIDTH-bit operands are split into STAGES chunks. Each pipeline stage adds one chunk and registers its carry for the next stage, so one operation is accepted per cycle.
- Provides a global stall, carry-out and signed overflow.
- Serves as the arithmetic datapath feeding the register-file experiments.

Parameters:
- WIDTH, 32: operand/result width. Must be ≥2 and divisible by STAGES.
- STAGES, 4: pipeline depth. Must be ≥1. Each stage handles CHUNK = WIDTH/STAGES bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  pipeline advance. 0 = every register holds.
- in_valid  in  1  operand set present this cycle
- sub  in  1  0 = add, 1 = subtract
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result registers hold a new result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB. For sub, 1 = no borrow.
- ovf  out  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Arithmetic:
  - B' = sub ? ~b : b
  - c0 = cin ^ sub
  - Result = a + B' + c0, modulo 2^WIDTH.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK], using the carry registered by stage k-1; stage 0 uses c0.
  - Operand chunks for later stages are skew-delayed.
  - Result chunks from earlier stages are de-skew-delayed, so all bits of one operation appear together.
- Latency: exactly STAGES rising edges with en=1 from the capture edge to out_valid=1. STAGES=1 gives a single registered adder.
- Stage register update rules:
  - Each stage has a valid bit. On an edge with en=1, valid[k] ← valid[k-1], and valid[0] ← in_valid.
  - A stage's data registers (chunk sum, carry, delayed operands/results) load only on edges with en=1 and incoming valid=1. Otherwise they hold.
  - Consequence: sum/cout/ovf hold the last valid result during bubbles.
- Stall:
  - en=0 freezes every register, valid bits included.
  - in_valid is ignored while en=0; the operation is not captured.
  - Transfer rule: a result is delivered on each rising edge where out_valid=1 and en=1. A held result is never delivered twice.
- Operation ordering:
  - Results emerge in input order, with no reordering or drops.
  - Back-to-back in_valid=1 gives back-to-back out_valid=1.
- Reset:
  - Edge with rst_n=0 clears all valid bits, all data registers, and sum/cout/ovf to 0.
  - Reset overrides en.
  - Reset mid-operation discards every in-flight operation.
  - An operation presented on the reset edge is not captured.
- Boundaries:
  - Carry must ripple across all chunk boundaries, e.g. all-ones + 1.
  - Mixed add/sub operations in consecutive cycles are independent: sub is carried with its chunk.
- No combinational path from inputs to outputs.

Decomposition:
- No shared-package typedefs are required. CHUNK stays a local constant computed from the parameters.
- Parameter legality (divisibility, WIDTH ≥2, STAGES ≥1) is checked at elaboration.
- Natural sub-module: adder_chunk.
  - Combinational CHUNK-bit ripple of 1-bit full-adder cells.
  - Outputs: chunk sum, carry out, and carry into its MSB (used only by the top chunk for ovf).
  - Instantiated STAGES times via generate.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=3, b=4. Required: out_valid=0 and sum=0 during reset and for 4 cycles after release. No result emerges.
- Full carry ripple (WIDTH=32, STAGES=4): a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0. Required: 4 cycles later, out_valid=1, sum=0x00000000, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFFFFFF, b=1 → sum=0x80000000, cout=0, ovf=1.
  - Then a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0. Same with cin=1 → sum=0xFFFFFFFD.
- Stream with stall: 6 consecutive ops (a=i, b=10*i, alternating sub). Drop en for 3 cycles after the 3rd capture. Required:
  - All registers frozen during the stall.
  - Exactly 6 deliveries (out_valid & en) in order with correct values.
  - Total latency of each op increases by exactly 3.
- Reset mid-flight: inject 3 ops, then rst_n=0 for one edge. Required: out_valid=0 and sum=0 next cycle, and none of the 3 results ever appear. An op issued right after reset emerges 4 cycles later, correct.
